alu_4bit: RTL and testbench

ALU_4BIT -- requirements
Module: alu_4bit

---
 rtl/alu_4bit.sv | 117 +++++++++++
 tb/tb_alu_4bit.sv | 105 ++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// alu_4bit: registered 4-bit ALU with carry/borrow/shift-out flag.
// Arithmetic goes through a per-bit ripple chain built from alu_4bit_slice
// instances. Logic and shift results come straight from operand vectors.

// One full-adder bit of the add/subtract ripple chain.
module alu_4bit_slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Plain full adder. Subtraction is handled by the caller, which feeds ~b and cin=1.
   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

module alu_4bit (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] alu_sel,
   output logic [3:0] alu_out,
   output logic       carry_out
);

   localparam int W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   alu_op_e        op;
   logic           is_sub;
   logic [W-1:0]   b_eff;
   logic [W:0]     chain;
   logic [W-1:0]   sum;
   logic [W-1:0]   res_d;
   logic           cy_d;

   assign op     = alu_op_e'(alu_sel);
   assign is_sub = (op == OP_SUB);

   // Subtract as a + ~b + 1. Borrow is the inverse of the chain's carry out.
   assign b_eff    = is_sub ? ~b : b;
   assign chain[0] = is_sub;

   genvar i;
   generate
      for (i = 0; i < W; i++) begin : g_bit
         alu_4bit_slice u_slice (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (chain[i]),
            .sum  (sum[i]),
            .cout (chain[i+1])
         );
      end
   endgenerate

   // Decode the operation from the current alu_sel. Every code is defined,
   // so the outputs never carry X when the inputs are known.
   always_comb begin
      res_d = '0;
      cy_d  = 1'b0;
      case (op)
         OP_ADD: begin
            res_d = sum;
            cy_d  = chain[W];
         end
         OP_SUB: begin
            res_d = sum;
            cy_d  = ~chain[W];
         end
         OP_AND: res_d = a & b;
         OP_OR:  res_d = a | b;
         OP_XOR: res_d = a ^ b;
         OP_NOT: res_d = ~a;
         OP_SHL: begin
            res_d = {a[W-2:0], 1'b0};
            cy_d  = a[W-1];
         end
         OP_SHR: begin
            res_d = {1'b0, a[W-1:1]};
            cy_d  = a[0];
         end
         default: begin
            res_d = '0;
            cy_d  = 1'b0;
         end
      endcase
   end

   // Output register: a synchronous reset wins over the result computed in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out   <= '0;
         carry_out <= 1'b0;
      end else begin
         alu_out   <= res_d;
         carry_out <= cy_d;
      end
   end

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed-vector bench for alu_4bit with hand-computed expectations.
module tb_alu_4bit;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] alu_sel;
   logic [3:0] alu_out;
   logic       carry_out;

   int n_checks = 0;
   int n_errors = 0;

   alu_4bit dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] eo, input logic ec);
      n_checks++;
      assert (alu_out === eo && carry_out === ec) else begin
         n_errors++;
         $error("FAIL %s: observed out=%b c=%b expected out=%b c=%b",
                tag, alu_out, carry_out, eo, ec);
      end
   endtask

   // Drive inputs mid-cycle, clock one edge, then sample 1 time unit later.
   task automatic step(input logic r, input logic [3:0] va, input logic [3:0] vb,
                       input logic [2:0] vs, input string tag,
                       input logic [3:0] eo, input logic ec);
      @(negedge clk);
      rst     = r;
      a       = va;
      b       = vb;
      alu_sel = vs;
      @(posedge clk);
      #1;
      check(tag, eo, ec);
   endtask

   initial begin
      rst = 1'b1; a = 4'hF; b = 4'hF; alu_sel = 3'b000;

      // reset for two edges with all-ones operands
      step(1'b1, 4'hF, 4'hF, 3'b000, "rst_edge1", 4'b0000, 1'b0);
      step(1'b1, 4'hF, 4'hF, 3'b000, "rst_edge2", 4'b0000, 1'b0);

      // sweep of all opcodes on a=0101 b=0011
      step(1'b0, 4'b0101, 4'b0011, 3'b000, "sweep_add", 4'b1000, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b001, "sweep_sub", 4'b0010, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b010, "sweep_and", 4'b0001, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b011, "sweep_or",  4'b0111, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b100, "sweep_xor", 4'b0110, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b101, "sweep_not", 4'b1010, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b110, "sweep_shl", 4'b1010, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b111, "sweep_shr", 4'b0010, 1'b1);

      // add wrap
      step(1'b0, 4'b1111, 4'b0001, 3'b000, "add_wrap1", 4'b0000, 1'b1);
      step(1'b0, 4'b1111, 4'b1111, 3'b000, "add_wrap2", 4'b1110, 1'b1);

      // sub borrow / equal
      step(1'b0, 4'b0011, 4'b0101, 3'b001, "sub_borrow", 4'b1110, 1'b1);
      step(1'b0, 4'b0111, 4'b0111, 3'b001, "sub_equal",  4'b0000, 1'b0);
      step(1'b0, 4'b0000, 4'b0001, 3'b001, "sub_zero_m1", 4'b1111, 1'b1);

      // shifts; b is ignored
      step(1'b0, 4'b1001, 4'b1111, 3'b110, "shl_1001", 4'b0010, 1'b1);
      step(1'b0, 4'b1001, 4'b0000, 3'b111, "shr_1001", 4'b0100, 1'b1);
      step(1'b0, 4'b0110, 4'b1010, 3'b101, "not_0110", 4'b1001, 1'b0);

      // hold: change inputs between edges, outputs must not move
      step(1'b0, 4'b0010, 4'b0011, 3'b000, "hold_base", 4'b0101, 1'b0);
      @(negedge clk);
      a = 4'b1111; alu_sel = 3'b101;
      #2;
      check("hold_mid", 4'b0101, 1'b0);
      @(posedge clk);
      #1;
      check("hold_next", 4'b0000, 1'b0);

      // reset in the middle of a sweep, then resume
      step(1'b0, 4'b0101, 4'b0011, 3'b000, "rs_add", 4'b1000, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b001, "rs_sub", 4'b0010, 1'b0);
      step(1'b1, 4'b0101, 4'b0011, 3'b010, "rs_reset", 4'b0000, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b010, "rs_and", 4'b0001, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b011, "rs_or",  4'b0111, 1'b0);
      step(1'b1, 4'b1111, 4'b0001, 3'b000, "rs_prio", 4'b0000, 1'b0);
      step(1'b0, 4'b0101, 4'b0011, 3'b111, "rs_shr", 4'b0010, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
